// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: shares the byte-wide peripheral data bus between two
// masters (m0 = CPU load/store, m1 = debug/loader). A winning request is
// latched in IDLE, drives the bus for ACCESS_CYCLES cycles, and then returns
// read data with a one-cycle done pulse. An illegal mode or an out-of-window
// address keeps select low and reports m_err together with done.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   -> a tie goes to the master that did not win last
//   undefined -> fixed priority, m0 wins every tie
module periph_bus_arbiter #(
  parameter logic [31:0] ADDR_BASE     = 32'h0000_40F0,
  parameter logic [31:0] ADDR_SPAN     = 32'h0000_0010,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_mode,
  input  logic [7:0]  m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_mode,
  input  logic [7:0]  m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [7:0]  m_rdata,
  output logic        m_err,
  output logic [31:0] data_bus_addr,
  output logic [1:0]  data_bus_mode,
  output logic [7:0]  data_bus_write,
  output logic        data_bus_select,
  input  logic [7:0]  data_bus_read
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  // The window is compared in 33 bits so that a window whose end passes
  // 2^32 is detected; such a window never matches.
  localparam logic [32:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, ADDR_BASE} + {1'b0, ADDR_SPAN};
  localparam logic        WIN_OK = (WIN_HI <= 33'h1_0000_0000);
  localparam logic [3:0]  CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        merr_q, merr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [1:0]  bus_mode_q, bus_mode_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        bus_sel_q, bus_sel_d;

  logic        pick_m1;
  logic [31:0] req_addr;
  logic [1:0]  req_mode;
  logic [7:0]  req_wdata;
  logic        mode_legal;
  logic        in_window;
  logic        hit;

  // Arbitration: choose which requester wins when the FSM is idle.
  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    pick_m1 = 1'b0;
    if (m1_req && !m0_req) begin
      pick_m1 = 1'b1;
    end else if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_m1 = ~last_q;
`else
      pick_m1 = 1'b0;
`endif
    end
  end

  // Request mux and legality decode of the winning master's request.
  always_comb begin
    req_addr   = pick_m1 ? m1_addr  : m0_addr;
    req_mode   = pick_m1 ? m1_mode  : m0_mode;
    req_wdata  = pick_m1 ? m1_wdata : m0_wdata;
    mode_legal = (req_mode == MODE_READ) || (req_mode == MODE_WRITE);
    in_window  = WIN_OK && ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
    hit        = mode_legal && in_window;
  end

  // Next-state and next-output logic of the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    id_d        = id_q;
    err_d       = err_q;
    rd_d        = rd_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    rdata_d     = rdata_q;
    merr_d      = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_mode_d  = bus_mode_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d     = S_ACCESS;
          cnt_d       = CNT_INIT;
          id_d        = pick_m1;
          err_d       = ~hit;
          rd_d        = hit && (req_mode == MODE_READ);
          gnt0_d      = ~pick_m1;
          gnt1_d      = pick_m1;
          bus_addr_d  = req_addr;
          bus_wdata_d = req_wdata;
          bus_mode_d  = hit ? req_mode : 2'b00;
          bus_sel_d   = hit;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_DONE;
          rdata_d     = rd_q ? data_bus_read : 8'h00;
          done0_d     = ~id_q;
          done1_d     = id_q;
          merr_d      = err_q;
          gnt0_d      = 1'b0;
          gnt1_d      = 1'b0;
          bus_addr_d  = 32'h0;
          bus_wdata_d = 8'h00;
          bus_mode_d  = 2'b00;
          bus_sel_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = id_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata_q     <= 8'h00;
      merr_q      <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_mode_q  <= 2'b00;
      bus_wdata_q <= 8'h00;
      bus_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      id_q        <= id_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata_q     <= rdata_d;
      merr_q      <= merr_d;
      bus_addr_q  <= bus_addr_d;
      bus_mode_q  <= bus_mode_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
    end
  end

  assign m0_gnt          = gnt0_q;
  assign m1_gnt          = gnt1_q;
  assign m0_done         = done0_q;
  assign m1_done         = done1_q;
  assign m_rdata         = rdata_q;
  assign m_err           = merr_q;
  assign data_bus_addr   = bus_addr_q;
  assign data_bus_mode   = bus_mode_q;
  assign data_bus_write  = bus_wdata_q;
  assign data_bus_select = bus_sel_q;

endmodule
